// File: rtl/sync_evt_arb_if.sv
// Signal bundle between the event arbiter and its requesters / CDC channel.
// Handshake: a requester raises its req bit and holds it until it sees its
// done bit pulse (acknowledged) or the arbiter reports timeout_err; t_out
// launches exactly one event per grant and ack_p closes it.
interface sync_evt_arb_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] done;
    logic               t_out;
    logic [ID_W-1:0]    id_out;
    logic               ack_p;
    logic               busy;
    logic               timeout_err;
    logic               stray_ack;

    // Arbiter side.
    modport master (
        input  req,
        input  ack_p,
        output done,
        output t_out,
        output id_out,
        output busy,
        output timeout_err,
        output stray_ack
    );

    // Requester / CDC side.
    modport slave (
        output req,
        output ack_p,
        input  done,
        input  t_out,
        input  id_out,
        input  busy,
        input  timeout_err,
        input  stray_ack
    );
endinterface

// File: rtl/sync_evt_arb.sv
// Round-robin arbiter sharing one toggle-to-pulse event channel between
// NUM_REQ requesters. One event in flight at a time; lost acknowledges are
// recovered by a wait-cycle timeout. All outputs are registered.
module sync_evt_arb #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200
) (
    input  logic            clka,
    input  logic            clka_rst,
    sync_evt_arb_if.master  bus,
    output logic [1:0]      dbg_state,
    output logic [ID_W-1:0] dbg_ptr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2
    } state_t;

    // Last wait-counter value before the event is abandoned.
    localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               t_out_q, t_out_d;
    logic               busy_q, busy_d;
    logic               tmo_q, tmo_d;
    logic               stray_q, stray_d;

    logic               sel_valid;
    logic [ID_W-1:0]    sel_idx;
    logic [ID_W-1:0]    ptr_after;

    // Round-robin pick: first set req bit at or above the pointer, wrapping.
    always_comb begin
        int j;
        sel_valid = 1'b0;
        sel_idx   = '0;
        j         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!sel_valid && bus.req[j]) begin
                sel_valid = 1'b1;
                sel_idx   = ID_W'(j);
            end
        end
    end

    // Pointer value after the in-flight event completes (done or timeout).
    always_comb begin
        ptr_after = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        done_d  = '0;
        t_out_d = 1'b0;
        tmo_d   = 1'b0;
        stray_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_d   = '0;
                stray_d = bus.ack_p;
                if (sel_valid) begin
                    id_d    = sel_idx;
                    t_out_d = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                stray_d = bus.ack_p;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.ack_p) begin
                    // Acknowledge wins over a coincident timeout.
                    done_d  = NUM_REQ'(1) << id_q;
                    ptr_d   = ptr_after;
                    state_d = S_IDLE;
                end else if ((TIMEOUT != 0) && (cnt_q == TMO_LAST)) begin
                    tmo_d   = 1'b1;
                    ptr_d   = ptr_after;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any event silently.
    always_ff @(posedge clka) begin
        if (clka_rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            done_q  <= '0;
            t_out_q <= 1'b0;
            busy_q  <= 1'b0;
            tmo_q   <= 1'b0;
            stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            t_out_q <= t_out_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
            stray_q <= stray_d;
        end
    end

    assign bus.done        = done_q;
    assign bus.t_out       = t_out_q;
    assign bus.id_out      = id_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = tmo_q;
    assign bus.stray_ack   = stray_q;
    assign dbg_state       = state_q;
    assign dbg_ptr         = ptr_q;

endmodule

// File: tb/tb_sync_evt_arb.sv
// Directed bench for sync_evt_arb: grant order, latency, timeout,
// ack/timeout coincidence, stray acknowledges and reset mid-event.
module tb_sync_evt_arb;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 10;

    logic            clka = 1'b0;
    logic            clka_rst;
    logic [1:0]      dbg_state;
    logic [ID_W-1:0] dbg_ptr;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int last_t   = -1;

    sync_evt_arb_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

    sync_evt_arb #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W),
        .CNT_W  (CNT_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clka     (clka),
        .clka_rst (clka_rst),
        .bus      (bus),
        .dbg_state(dbg_state),
        .dbg_ptr  (dbg_ptr)
    );

    // Clock.
    always #5 clka = ~clka;

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one edge; inputs and checks happen 1 time unit after it.
    task automatic tick();
        @(posedge clka);
        #1;
        cyc++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_t_out"}, bus.t_out, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_tmo"}, bus.timeout_err, 0);
        check({tag, "_stray"}, bus.stray_ack, 0);
        check({tag, "_id"}, bus.id_out, 0);
        check({tag, "_ptr"}, dbg_ptr, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    task automatic do_reset();
        clka_rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        clka_rst = 1'b0;
        last_t   = -1;
    endtask

    // One full grant: launch on the next edge, ack driven ack_dly cycles
    // after t_out, done expected the cycle after the ack.
    task automatic grant_cycle(input logic [ID_W-1:0] exp_id, input int ack_dly,
                               input bit drop_req, input int exp_sp,
                               input logic [NUM_REQ-1:0] req_after);
        logic [NUM_REQ-1:0] exp_done;
        int exp_ptr;
        exp_done          = '0;
        exp_done[exp_id]  = 1'b1;
        exp_ptr           = (int'(exp_id) + 1) % NUM_REQ;
        tick();
        check("launch_t_out", bus.t_out, 1);
        check("launch_id", bus.id_out, exp_id);
        check("launch_busy", bus.busy, 1);
        check("launch_state", dbg_state, 1);
        check("launch_tmo", bus.timeout_err, 0);
        if (exp_sp != 0) check("t_out_spacing", cyc - last_t, exp_sp);
        last_t = cyc;
        if (drop_req) bus.req = '0;
        for (int i = 0; i < ack_dly; i++) begin
            tick();
            check("wait_t_out", bus.t_out, 0);
            check("wait_id", bus.id_out, exp_id);
            check("wait_busy", bus.busy, 1);
            check("wait_done", bus.done, 0);
            check("wait_tmo", bus.timeout_err, 0);
        end
        bus.ack_p = 1'b1;
        tick();
        bus.ack_p = 1'b0;
        check("done_vec", bus.done, exp_done);
        check("done_busy", bus.busy, 0);
        check("done_tmo", bus.timeout_err, 0);
        check("done_state", dbg_state, 0);
        check("done_ptr", dbg_ptr, exp_ptr);
        bus.req = req_after;
    endtask

    initial begin
        clka_rst    = 1'b1;
        bus.req     = '0;
        bus.ack_p   = 1'b0;

        // Single requester, ID 2.
        do_reset();
        bus.req = 4'b0100;
        grant_cycle(2'd2, 5, 1'b0, 0, 4'b0000);
        tick();
        check("after_done_clear", bus.done, 0);
        check("after_done_idle", dbg_state, 0);
        check("after_done_ptr", dbg_ptr, 3);

        // All requesting: rotation 0,1,2,3,0 with ack 5 cycles after t_out.
        do_reset();
        bus.req = 4'b1111;
        grant_cycle(2'd0, 5, 1'b0, 0, 4'b1111);
        grant_cycle(2'd1, 5, 1'b0, 7, 4'b1111);
        grant_cycle(2'd2, 5, 1'b0, 7, 4'b1111);
        grant_cycle(2'd3, 5, 1'b0, 7, 4'b1111);
        grant_cycle(2'd0, 5, 1'b0, 7, 4'b0000);
        tick();
        check("rr_end_idle", dbg_state, 0);
        check("rr_end_t_out", bus.t_out, 0);

        // Timeout on ID 1 (pointer is 1 here).
        bus.req = 4'b0010;
        tick();
        check("tmo_launch_t_out", bus.t_out, 1);
        check("tmo_launch_id", bus.id_out, 1);
        for (int i = 0; i < TIMEOUT; i++) begin
            tick();
            check("tmo_wait_err", bus.timeout_err, 0);
            check("tmo_wait_busy", bus.busy, 1);
        end
        tick();
        check("tmo_err", bus.timeout_err, 1);
        check("tmo_done", bus.done, 0);
        check("tmo_busy", bus.busy, 0);
        check("tmo_state", dbg_state, 0);
        check("tmo_ptr", dbg_ptr, 2);

        // Next grant ID 2, ack lands exactly on the timeout cycle.
        bus.req = 4'b0100;
        grant_cycle(2'd2, TIMEOUT, 1'b0, 0, 4'b0000);
        tick();
        check("coinc_no_tmo", bus.timeout_err, 0);

        // Stray ack while idle.
        tick();
        bus.ack_p = 1'b1;
        tick();
        bus.ack_p = 1'b0;
        check("stray_idle", bus.stray_ack, 1);
        check("stray_done", bus.done, 0);
        check("stray_state", dbg_state, 0);
        check("stray_busy", bus.busy, 0);
        tick();
        check("stray_pulse_end", bus.stray_ack, 0);

        // Reset in WAIT with ID 3 in flight.
        bus.req = 4'b1000;
        tick();
        check("rw_launch_id", bus.id_out, 3);
        check("rw_launch_t_out", bus.t_out, 1);
        tick();
        tick();
        check("rw_in_wait", dbg_state, 2);
        clka_rst = 1'b1;
        tick();
        clka_rst = 1'b0;
        bus.req  = '0;
        check_all_zero("rw_reset");
        bus.ack_p = 1'b1;
        tick();
        bus.ack_p = 1'b0;
        check("rw_stray", bus.stray_ack, 1);
        check("rw_no_done", bus.done, 0);
        for (int i = 0; i < TIMEOUT + 2; i++) begin
            tick();
            check("rw_no_tmo", bus.timeout_err, 0);
        end
        // Requester 3 again; it drops req during the event and still gets done.
        bus.req = 4'b1000;
        grant_cycle(2'd3, 2, 1'b1, 0, 4'b0000);
        tick();
        check("final_idle", dbg_state, 0);
        check("final_ptr", dbg_ptr, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
